ahb_arb_2m1s: RTL and testbench

AHB_ARB_2M1S -- requirements
Module: ahb_arb_2m1s

---
 rtl/ahb_arb_2m1s.sv | 228 ++++++++++++++++++++++
 tb/tb_ahb_arb_2m1s.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arb_2m1s.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arb_2m1s
// Description : Two-master, one-slave AHB-Lite arbiter. An uncontended live
//               request passes straight through to the slave in the same
//               cycle. A losing request is captured into a per-master pending
//               buffer, and the master is stalled until that buffered
//               transfer has been issued to the slave.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : FIXED_PRIO - 0: round-robin between the two masters
//                            1: M0 wins every contention
// Ports       : CLK, RES              - clock, asynchronous active-high reset
//               Mx_HTRANS..Mx_HWDATA  - master x address/data-phase inputs
//               Mx_HREADY/HRDATA/HRESP- master x response outputs
//               S_HSEL..S_HREADY      - slave request outputs
//               S_HREADYOUT/HRDATA/HRESP - slave response inputs
// ============================================================================
module ahb_arb_2m1s #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        CLK,
  input  logic        RES,
  // Master 0
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic        M0_HMASTLOCK,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic [31:0] M0_HADDR,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HRESP,
  // Master 1
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic        M1_HMASTLOCK,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic [31:0] M1_HADDR,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HRESP,
  // Slave
  output logic        S_HSEL,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic        S_HMASTLOCK,
  output logic [2:0]  S_HSIZE,
  output logic [2:0]  S_HBURST,
  output logic [3:0]  S_HPROT,
  output logic [31:0] S_HADDR,
  output logic [31:0] S_HWDATA,
  output logic        S_HREADY,
  input  logic        S_HREADYOUT,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HRESP
);

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] c_OWN_NONE      = 2'b00;

  // Per-master views of the request inputs; index 0 = M0, index 1 = M1.
  logic [1:0][1:0]  w_htrans;
  logic [1:0]       w_hwrite;
  logic [1:0]       w_hlock;
  logic [1:0][2:0]  w_hsize;
  logic [1:0][2:0]  w_hburst;
  logic [1:0][3:0]  w_hprot;
  logic [1:0][31:0] w_haddr;

  assign w_htrans = {M1_HTRANS,    M0_HTRANS};
  assign w_hwrite = {M1_HWRITE,    M0_HWRITE};
  assign w_hlock  = {M1_HMASTLOCK, M0_HMASTLOCK};
  assign w_hsize  = {M1_HSIZE,     M0_HSIZE};
  assign w_hburst = {M1_HBURST,    M0_HBURST};
  assign w_hprot  = {M1_HPROT,     M0_HPROT};
  assign w_haddr  = {M1_HADDR,     M0_HADDR};

  // Pending buffers (address-phase copy of a request that lost arbitration)
  logic [1:0]       r_pend;
  logic [1:0]       r_pwrite;
  logic [1:0]       r_plock;
  logic [1:0][2:0]  r_psize;
  logic [1:0][2:0]  r_pburst;
  logic [1:0][3:0]  r_pprot;
  logic [1:0][31:0] r_paddr;

  // Ownership state, one-hot per master, 2'b00 = none
  logic [1:0] r_dp_own;
  logic [1:0] r_lock_own;
  logic       r_last_gnt;   // 0 = M0 granted last, 1 = M1 granted last

  logic       w_slot_free;
  logic [1:0] w_hready;
  logic [1:0] w_live;
  logic [1:0] w_cand;
  logic [1:0] w_gnt;
  logic       w_sel;
  logic       w_from_buf;
  logic       w_tie_m0;
  logic       w_iss_lock;

  assign w_slot_free = S_HREADYOUT;

  // A master is stalled while its buffered transfer waits, or while its own
  // data phase is being extended by the slave.
  assign w_hready = ~(r_pend | (r_dp_own & {2{~S_HREADYOUT}}));
  assign w_live   = w_hready & {w_htrans[1][1], w_htrans[0][1]};
  assign w_cand   = r_pend | w_live;

  // Tie-break between two candidates of the same class
  assign w_tie_m0 = (FIXED_PRIO != 0) || r_last_gnt;

  // Grant selection. Only evaluated when the slave can take an address phase
  // and never while reset is held, so reset alone keeps the slave idle.
  // In fixed-priority mode M0 wins every contention, even against a buffered
  // M1 request; otherwise a buffered request outranks a live one.
  always_comb begin
    w_gnt = 2'b00;
    if (w_slot_free && !RES) begin
      if (r_lock_own[0]) begin
        w_gnt[0] = w_cand[0];
      end else if (r_lock_own[1]) begin
        w_gnt[1] = w_cand[1];
      end else if (FIXED_PRIO != 0) begin
        if (w_cand[0])      w_gnt = 2'b01;
        else if (w_cand[1]) w_gnt = 2'b10;
      end else if (r_pend[0] && r_pend[1]) begin
        w_gnt = w_tie_m0 ? 2'b01 : 2'b10;
      end else if (r_pend[0]) begin
        w_gnt = 2'b01;
      end else if (r_pend[1]) begin
        w_gnt = 2'b10;
      end else if (w_live[0] && w_live[1]) begin
        w_gnt = w_tie_m0 ? 2'b01 : 2'b10;
      end else if (w_live[0]) begin
        w_gnt = 2'b01;
      end else if (w_live[1]) begin
        w_gnt = 2'b10;
      end
    end
  end

  assign w_sel      = w_gnt[1];
  assign w_from_buf = r_pend[w_sel];
  assign w_iss_lock = w_from_buf ? r_plock[w_sel] : w_hlock[w_sel];

  // Slave address phase. A buffered transfer is always reissued as NONSEQ,
  // since the beat that preceded it may not be the last thing the slave saw.
  always_comb begin
    S_HSEL      = |w_gnt;
    S_HTRANS    = c_HTRANS_IDLE;
    if (|w_gnt) begin
      S_HTRANS  = w_from_buf ? c_HTRANS_NONSEQ : w_htrans[w_sel];
    end
    S_HWRITE    = w_from_buf ? r_pwrite[w_sel] : w_hwrite[w_sel];
    S_HMASTLOCK = w_iss_lock;
    S_HSIZE     = w_from_buf ? r_psize[w_sel]  : w_hsize[w_sel];
    S_HBURST    = w_from_buf ? r_pburst[w_sel] : w_hburst[w_sel];
    S_HPROT     = w_from_buf ? r_pprot[w_sel]  : w_hprot[w_sel];
    S_HADDR     = w_from_buf ? r_paddr[w_sel]  : w_haddr[w_sel];
  end

  // Pending buffers: cleared by issue, set by a live request that lost.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_pend   <= 2'b00;
      r_pwrite <= 2'b00;
      r_plock  <= 2'b00;
      r_psize  <= '0;
      r_pburst <= '0;
      r_pprot  <= '0;
      r_paddr  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_gnt[i]) begin
          r_pend[i]   <= 1'b0;
        end else if (w_live[i]) begin
          r_pend[i]   <= 1'b1;
          r_pwrite[i] <= w_hwrite[i];
          r_plock[i]  <= w_hlock[i];
          r_psize[i]  <= w_hsize[i];
          r_pburst[i] <= w_hburst[i];
          r_pprot[i]  <= w_hprot[i];
          r_paddr[i]  <= w_haddr[i];
        end
      end
    end
  end

  // Data-phase owner, lock owner and round-robin history all move only on
  // edges where the slave accepts an address phase.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_dp_own   <= c_OWN_NONE;
      r_lock_own <= c_OWN_NONE;
      r_last_gnt <= 1'b1;
    end else if (w_slot_free) begin
      r_dp_own <= w_gnt;
      if (|w_gnt) begin
        r_last_gnt <= w_gnt[1];
        r_lock_own <= w_iss_lock ? w_gnt : c_OWN_NONE;
      end else if ((r_lock_own & w_hready & ~w_hlock) != c_OWN_NONE) begin
        // Lock owner idled with HMASTLOCK dropped: release the lock.
        r_lock_own <= c_OWN_NONE;
      end
    end
  end

  // Data-phase routing
  assign S_HREADY  = S_HREADYOUT;
  assign S_HWDATA  = r_dp_own[1] ? M1_HWDATA : (r_dp_own[0] ? M0_HWDATA : 32'h0);

  assign M0_HREADY = w_hready[0];
  assign M1_HREADY = w_hready[1];
  assign M0_HRDATA = r_dp_own[0] ? S_HRDATA : 32'h0;
  assign M1_HRDATA = r_dp_own[1] ? S_HRDATA : 32'h0;
  assign M0_HRESP  = r_dp_own[0] & S_HRESP;
  assign M1_HRESP  = r_dp_own[1] & S_HRESP;

endmodule
`default_nettype wire

// File: tb/tb_ahb_arb_2m1s.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_arb_2m1s
// Description : Directed self-checking bench for ahb_arb_2m1s. Instantiates a
//               round-robin copy (dut) and a fixed-priority copy (dut_fp)
//               sharing the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_arb_2m1s;

  localparam logic [1:0] c_TR_IDLE   = 2'b00;
  localparam logic [1:0] c_TR_NONSEQ = 2'b10;
  localparam logic [1:0] c_TR_SEQ    = 2'b11;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE, M0_HMASTLOCK, M1_HMASTLOCK;
  logic [2:0]  M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;
  logic [3:0]  M0_HPROT, M1_HPROT;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
  logic        S_HREADYOUT, S_HRESP;
  logic [31:0] S_HRDATA;

  // Round-robin instance outputs
  logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic        S_HSEL, S_HWRITE, S_HMASTLOCK, S_HREADY;
  logic [1:0]  S_HTRANS;
  logic [2:0]  S_HSIZE, S_HBURST;
  logic [3:0]  S_HPROT;
  logic [31:0] S_HADDR, S_HWDATA;

  // Fixed-priority instance outputs
  logic        fp_M0_HREADY, fp_M1_HREADY, fp_M0_HRESP, fp_M1_HRESP;
  logic [31:0] fp_M0_HRDATA, fp_M1_HRDATA;
  logic        fp_S_HSEL, fp_S_HWRITE, fp_S_HMASTLOCK, fp_S_HREADY;
  logic [1:0]  fp_S_HTRANS;
  logic [2:0]  fp_S_HSIZE, fp_S_HBURST;
  logic [3:0]  fp_S_HPROT;
  logic [31:0] fp_S_HADDR, fp_S_HWDATA;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  ahb_arb_2m1s #(.FIXED_PRIO(0)) dut (
    .CLK(CLK), .RES(RES),
    .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HMASTLOCK(M0_HMASTLOCK),
    .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT),
    .M0_HADDR(M0_HADDR), .M0_HWDATA(M0_HWDATA),
    .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA), .M0_HRESP(M0_HRESP),
    .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HMASTLOCK(M1_HMASTLOCK),
    .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT),
    .M1_HADDR(M1_HADDR), .M1_HWDATA(M1_HWDATA),
    .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA), .M1_HRESP(M1_HRESP),
    .S_HSEL(S_HSEL), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
    .S_HMASTLOCK(S_HMASTLOCK), .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST),
    .S_HPROT(S_HPROT), .S_HADDR(S_HADDR), .S_HWDATA(S_HWDATA),
    .S_HREADY(S_HREADY), .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA),
    .S_HRESP(S_HRESP)
  );

  ahb_arb_2m1s #(.FIXED_PRIO(1)) dut_fp (
    .CLK(CLK), .RES(RES),
    .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HMASTLOCK(M0_HMASTLOCK),
    .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT),
    .M0_HADDR(M0_HADDR), .M0_HWDATA(M0_HWDATA),
    .M0_HREADY(fp_M0_HREADY), .M0_HRDATA(fp_M0_HRDATA), .M0_HRESP(fp_M0_HRESP),
    .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HMASTLOCK(M1_HMASTLOCK),
    .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT),
    .M1_HADDR(M1_HADDR), .M1_HWDATA(M1_HWDATA),
    .M1_HREADY(fp_M1_HREADY), .M1_HRDATA(fp_M1_HRDATA), .M1_HRESP(fp_M1_HRESP),
    .S_HSEL(fp_S_HSEL), .S_HTRANS(fp_S_HTRANS), .S_HWRITE(fp_S_HWRITE),
    .S_HMASTLOCK(fp_S_HMASTLOCK), .S_HSIZE(fp_S_HSIZE), .S_HBURST(fp_S_HBURST),
    .S_HPROT(fp_S_HPROT), .S_HADDR(fp_S_HADDR), .S_HWDATA(fp_S_HWDATA),
    .S_HREADY(fp_S_HREADY), .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA),
    .S_HRESP(S_HRESP)
  );

  // Advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_m0(input logic [1:0] tr, input logic wr, input logic lk, input logic [31:0] ad);
    M0_HTRANS = tr; M0_HWRITE = wr; M0_HMASTLOCK = lk; M0_HADDR = ad;
    M0_HSIZE = 3'd2; M0_HBURST = 3'd0; M0_HPROT = 4'h3;
  endtask

  task automatic drive_m1(input logic [1:0] tr, input logic wr, input logic lk, input logic [31:0] ad);
    M1_HTRANS = tr; M1_HWRITE = wr; M1_HMASTLOCK = lk; M1_HADDR = ad;
    M1_HSIZE = 3'd2; M1_HBURST = 3'd0; M1_HPROT = 4'h3;
  endtask

  task automatic idle_all();
    drive_m0(c_TR_IDLE, 1'b0, 1'b0, 32'h0);
    drive_m1(c_TR_IDLE, 1'b0, 1'b0, 32'h0);
    M0_HWDATA = 32'h0; M1_HWDATA = 32'h0;
    S_HREADYOUT = 1'b1; S_HRDATA = 32'h0; S_HRESP = 1'b0;
  endtask

  task automatic do_reset();
    RES = 1'b1;
    idle_all();
    repeat (2) @(posedge CLK);
    #1;
    RES = 1'b0;
  endtask

  // Outputs held quiet during reset even with both masters requesting
  task automatic test_reset();
    RES = 1'b1;
    idle_all();
    drive_m0(c_TR_NONSEQ, 1'b0, 1'b0, 32'h100);
    drive_m1(c_TR_NONSEQ, 1'b1, 1'b0, 32'h200);
    S_HRDATA = 32'hDEADBEEF; S_HRESP = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    total++; if (S_HSEL !== 1'b0) begin bad++; $display("FAIL rst_hsel: got %h want 0", S_HSEL); end
    total++; if (S_HTRANS !== c_TR_IDLE) begin bad++; $display("FAIL rst_htrans: got %h want 0", S_HTRANS); end
    total++; if (M0_HREADY !== 1'b1) begin bad++; $display("FAIL rst_m0_hready: got %h want 1", M0_HREADY); end
    total++; if (M1_HREADY !== 1'b1) begin bad++; $display("FAIL rst_m1_hready: got %h want 1", M1_HREADY); end
    total++; if (M0_HRDATA !== 32'h0) begin bad++; $display("FAIL rst_m0_hrdata: got %h want 0", M0_HRDATA); end
    total++; if (M1_HRDATA !== 32'h0) begin bad++; $display("FAIL rst_m1_hrdata: got %h want 0", M1_HRDATA); end
    total++; if (M0_HRESP !== 1'b0) begin bad++; $display("FAIL rst_m0_hresp: got %h want 0", M0_HRESP); end
    total++; if (fp_S_HSEL !== 1'b0) begin bad++; $display("FAIL rst_fp_hsel: got %h want 0", fp_S_HSEL); end
  endtask

  // Lone M0 read: zero-latency address, read data next cycle
  task automatic test_single_read();
    do_reset();
    drive_m0(c_TR_NONSEQ, 1'b0, 1'b0, 32'h100);
    #1;
    total++; if (S_HSEL !== 1'b1) begin bad++; $display("FAIL single_hsel: got %h want 1", S_HSEL); end
    total++; if (S_HADDR !== 32'h100) begin bad++; $display("FAIL single_haddr: got %h want 100", S_HADDR); end
    total++; if (S_HTRANS !== c_TR_NONSEQ) begin bad++; $display("FAIL single_htrans: got %h want 2", S_HTRANS); end
    total++; if (S_HSIZE !== 3'd2) begin bad++; $display("FAIL single_hsize: got %h want 2", S_HSIZE); end
    cyc();
    drive_m0(c_TR_IDLE, 1'b0, 1'b0, 32'h0);
    S_HRDATA = 32'h12345678;
    #1;
    total++; if (M0_HRDATA !== 32'h12345678) begin bad++; $display("FAIL single_rdata: got %h want 12345678", M0_HRDATA); end
    total++; if (M1_HRDATA !== 32'h0) begin bad++; $display("FAIL single_m1_rdata: got %h want 0", M1_HRDATA); end
    total++; if (M1_HREADY !== 1'b1) begin bad++; $display("FAIL single_m1_hready: got %h want 1", M1_HREADY); end
    total++; if (S_HSEL !== 1'b0) begin bad++; $display("FAIL single_hsel_idle: got %h want 0", S_HSEL); end
    cyc();
  endtask

  // Simultaneous requests after reset: M0 first, M1 buffered then issued
  task automatic test_contention();
    do_reset();
    drive_m0(c_TR_NONSEQ, 1'b1, 1'b0, 32'h10);
    drive_m1(c_TR_NONSEQ, 1'b0, 1'b0, 32'h20);
    #1;
    total++; if (S_HADDR !== 32'h10) begin bad++; $display("FAIL cont_first_addr: got %h want 10", S_HADDR); end
    total++; if (S_HWRITE !== 1'b1) begin bad++; $display("FAIL cont_first_write: got %h want 1", S_HWRITE); end
    cyc();
    drive_m0(c_TR_IDLE, 1'b0, 1'b0, 32'h0);
    drive_m1(c_TR_IDLE, 1'b0, 1'b0, 32'h0);
    M0_HWDATA = 32'hA5;
    #1;
    total++; if (M1_HREADY !== 1'b0) begin bad++; $display("FAIL cont_m1_stall: got %h want 0", M1_HREADY); end
    total++; if (S_HTRANS !== c_TR_NONSEQ) begin bad++; $display("FAIL cont_second_htrans: got %h want 2", S_HTRANS); end
    total++; if (S_HADDR !== 32'h20) begin bad++; $display("FAIL cont_second_addr: got %h want 20", S_HADDR); end
    total++; if (S_HWRITE !== 1'b0) begin bad++; $display("FAIL cont_second_write: got %h want 0", S_HWRITE); end
    total++; if (S_HWDATA !== 32'hA5) begin bad++; $display("FAIL cont_hwdata: got %h want a5", S_HWDATA); end
    cyc();
    S_HRDATA = 32'hA5;
    #1;
    total++; if (M1_HRDATA !== 32'hA5) begin bad++; $display("FAIL cont_readback: got %h want a5", M1_HRDATA); end
    total++; if (M1_HREADY !== 1'b1) begin bad++; $display("FAIL cont_m1_done: got %h want 1", M1_HREADY); end
    total++; if (M0_HRDATA !== 32'h0) begin bad++; $display("FAIL cont_m0_rdata: got %h want 0", M0_HRDATA); end
    cyc();
  endtask

  // Round-robin: M1 wins the tie after M0, buffered SEQ reissued as NONSEQ
  task automatic test_round_robin();
    do_reset();
    drive_m0(c_TR_NONSEQ, 1'b0, 1'b0, 32'h200);
    cyc();
    drive_m0(c_TR_SEQ, 1'b0, 1'b0, 32'h204);
    drive_m1(c_TR_NONSEQ, 1'b0, 1'b0, 32'h300);
    #1;
    total++; if (S_HADDR !== 32'h300) begin bad++; $display("FAIL rr_m1_addr: got %h want 300", S_HADDR); end
    total++; if (M0_HREADY !== 1'b1) begin bad++; $display("FAIL rr_m0_ready: got %h want 1", M0_HREADY); end
    cyc();
    drive_m0(c_TR_SEQ, 1'b0, 1'b0, 32'h208);
    drive_m1(c_TR_IDLE, 1'b0, 1'b0, 32'h0);
    #1;
    total++; if (S_HADDR !== 32'h204) begin bad++; $display("FAIL rr_buf_addr: got %h want 204", S_HADDR); end
    total++; if (S_HTRANS !== c_TR_NONSEQ) begin bad++; $display("FAIL rr_buf_htrans: got %h want 2", S_HTRANS); end
    total++; if (M0_HREADY !== 1'b0) begin bad++; $display("FAIL rr_m0_stall: got %h want 0", M0_HREADY); end
    cyc();
    #1;
    total++; if (S_HADDR !== 32'h208) begin bad++; $display("FAIL rr_live_addr: got %h want 208", S_HADDR); end
    total++; if (S_HTRANS !== c_TR_SEQ) begin bad++; $display("FAIL rr_live_htrans: got %h want 3", S_HTRANS); end
    cyc();
    idle_all();
  endtask

  // Fixed priority holds M1 off while M0 keeps requesting; round-robin does not
  task automatic test_fixed_prio();
    do_reset();
    drive_m0(c_TR_NONSEQ, 1'b0, 1'b0, 32'h400);
    drive_m1(c_TR_NONSEQ, 1'b0, 1'b0, 32'h500);
    #1;
    total++; if (S_HADDR !== 32'h400) begin bad++; $display("FAIL fp_rr_first: got %h want 400", S_HADDR); end
    total++; if (fp_S_HADDR !== 32'h400) begin bad++; $display("FAIL fp_first: got %h want 400", fp_S_HADDR); end
    cyc();
    drive_m0(c_TR_NONSEQ, 1'b0, 1'b0, 32'h404);
    drive_m1(c_TR_IDLE, 1'b0, 1'b0, 32'h0);
    #1;
    total++; if (fp_S_HADDR !== 32'h404) begin bad++; $display("FAIL fp_m0_again: got %h want 404", fp_S_HADDR); end
    total++; if (fp_M1_HREADY !== 1'b0) begin bad++; $display("FAIL fp_m1_stall: got %h want 0", fp_M1_HREADY); end
    total++; if (S_HADDR !== 32'h500) begin bad++; $display("FAIL fp_rr_m1: got %h want 500", S_HADDR); end
    total++; if (M0_HREADY !== 1'b1) begin bad++; $display("FAIL fp_rr_m0_ready: got %h want 1", M0_HREADY); end
    cyc();
    drive_m0(c_TR_IDLE, 1'b0, 1'b0, 32'h0);
    #1;
    total++; if (fp_S_HADDR !== 32'h500) begin bad++; $display("FAIL fp_m1_late: got %h want 500", fp_S_HADDR); end
    total++; if (fp_S_HTRANS !== c_TR_NONSEQ) begin bad++; $display("FAIL fp_m1_htrans: got %h want 2", fp_S_HTRANS); end
    total++; if (S_HADDR !== 32'h404) begin bad++; $display("FAIL fp_rr_m0_buf: got %h want 404", S_HADDR); end
    total++; if (M0_HREADY !== 1'b0) begin bad++; $display("FAIL fp_rr_m0_stall: got %h want 0", M0_HREADY); end
    cyc();
    idle_all();
  endtask

  // Locked M1 sequence blocks M0 until M1 issues with HMASTLOCK=0
  task automatic test_lock();
    do_reset();
    drive_m1(c_TR_NONSEQ, 1'b0, 1'b1, 32'h600);
    #1;
    total++; if (S_HMASTLOCK !== 1'b1) begin bad++; $display("FAIL lock_first: got %h want 1", S_HMASTLOCK); end
    cyc();
    drive_m1(c_TR_SEQ, 1'b0, 1'b1, 32'h604);
    drive_m0(c_TR_NONSEQ, 1'b1, 1'b0, 32'h700);
    #1;
    total++; if (S_HADDR !== 32'h604) begin bad++; $display("FAIL lock_second: got %h want 604", S_HADDR); end
    cyc();
    drive_m1(c_TR_SEQ, 1'b0, 1'b1, 32'h608);
    #1;
    total++; if (S_HADDR !== 32'h608) begin bad++; $display("FAIL lock_third: got %h want 608", S_HADDR); end
    total++; if (M0_HREADY !== 1'b0) begin bad++; $display("FAIL lock_m0_stall: got %h want 0", M0_HREADY); end
    cyc();
    drive_m1(c_TR_NONSEQ, 1'b0, 1'b0, 32'h60C);
    #1;
    total++; if (S_HADDR !== 32'h60C) begin bad++; $display("FAIL lock_unlock_addr: got %h want 60c", S_HADDR); end
    total++; if (S_HMASTLOCK !== 1'b0) begin bad++; $display("FAIL lock_unlock_flag: got %h want 0", S_HMASTLOCK); end
    cyc();
    drive_m1(c_TR_IDLE, 1'b0, 1'b0, 32'h0);
    #1;
    total++; if (S_HADDR !== 32'h700) begin bad++; $display("FAIL lock_m0_after: got %h want 700", S_HADDR); end
    total++; if (S_HWRITE !== 1'b1) begin bad++; $display("FAIL lock_m0_write: got %h want 1", S_HWRITE); end
    cyc();
    idle_all();
  endtask

  // Three wait states on M0 (last one starting an error response); M1 buffered
  task automatic test_wait_states();
    do_reset();
    drive_m0(c_TR_NONSEQ, 1'b1, 1'b0, 32'h800);
    cyc();
    drive_m0(c_TR_IDLE, 1'b0, 1'b0, 32'h0);
    M0_HWDATA = 32'h77;
    drive_m1(c_TR_NONSEQ, 1'b0, 1'b0, 32'h900);
    S_HREADYOUT = 1'b0;
    #1;
    total++; if (S_HSEL !== 1'b0) begin bad++; $display("FAIL ws_no_issue: got %h want 0", S_HSEL); end
    total++; if (M0_HREADY !== 1'b0) begin bad++; $display("FAIL ws_m0_wait: got %h want 0", M0_HREADY); end
    total++; if (M1_HREADY !== 1'b1) begin bad++; $display("FAIL ws_m1_live: got %h want 1", M1_HREADY); end
    total++; if (S_HWDATA !== 32'h77) begin bad++; $display("FAIL ws_hwdata: got %h want 77", S_HWDATA); end
    cyc();
    drive_m1(c_TR_IDLE, 1'b0, 1'b0, 32'h0);
    #1;
    total++; if (M1_HREADY !== 1'b0) begin bad++; $display("FAIL ws_m1_stall: got %h want 0", M1_HREADY); end
    cyc();
    S_HRESP = 1'b1;
    #1;
    total++; if (M0_HRESP !== 1'b1) begin bad++; $display("FAIL ws_err1_m0: got %h want 1", M0_HRESP); end
    total++; if (M1_HRESP !== 1'b0) begin bad++; $display("FAIL ws_err1_m1: got %h want 0", M1_HRESP); end
    total++; if (S_HSEL !== 1'b0) begin bad++; $display("FAIL ws_hold3: got %h want 0", S_HSEL); end
    cyc();
    S_HREADYOUT = 1'b1;
    #1;
    total++; if (S_HADDR !== 32'h900) begin bad++; $display("FAIL ws_m1_issue: got %h want 900", S_HADDR); end
    total++; if (S_HSEL !== 1'b1) begin bad++; $display("FAIL ws_m1_hsel: got %h want 1", S_HSEL); end
    total++; if (M0_HREADY !== 1'b1) begin bad++; $display("FAIL ws_m0_done: got %h want 1", M0_HREADY); end
    total++; if (M0_HRESP !== 1'b1) begin bad++; $display("FAIL ws_err2_m0: got %h want 1", M0_HRESP); end
    cyc();
    idle_all();
    cyc();
  endtask

  // Reset while M1 is buffered discards it; slave stays idle until new request
  task automatic test_reset_pending();
    do_reset();
    drive_m0(c_TR_NONSEQ, 1'b0, 1'b0, 32'hB00);
    drive_m1(c_TR_NONSEQ, 1'b0, 1'b0, 32'hC00);
    cyc();
    idle_all();
    S_HRDATA = 32'h5555;
    #1;
    total++; if (S_HADDR !== 32'hC00) begin bad++; $display("FAIL rp_before: got %h want c00", S_HADDR); end
    RES = 1'b1;
    #1;
    total++; if (S_HSEL !== 1'b0) begin bad++; $display("FAIL rp_hsel: got %h want 0", S_HSEL); end
    total++; if (S_HTRANS !== c_TR_IDLE) begin bad++; $display("FAIL rp_htrans: got %h want 0", S_HTRANS); end
    total++; if (M1_HREADY !== 1'b1) begin bad++; $display("FAIL rp_m1_ready: got %h want 1", M1_HREADY); end
    total++; if (M0_HRDATA !== 32'h0) begin bad++; $display("FAIL rp_m0_rdata: got %h want 0", M0_HRDATA); end
    cyc();
    RES = 1'b0;
    #1;
    total++; if (S_HSEL !== 1'b0) begin bad++; $display("FAIL rp_after_hsel: got %h want 0", S_HSEL); end
    total++; if (M1_HREADY !== 1'b1) begin bad++; $display("FAIL rp_after_m1: got %h want 1", M1_HREADY); end
    cyc();
    total++; if (S_HTRANS !== c_TR_IDLE) begin bad++; $display("FAIL rp_still_idle: got %h want 0", S_HTRANS); end
    drive_m1(c_TR_NONSEQ, 1'b0, 1'b0, 32'hA00);
    #1;
    total++; if (S_HADDR !== 32'hA00) begin bad++; $display("FAIL rp_new_req: got %h want a00", S_HADDR); end
    cyc();
    idle_all();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_round_robin();
    test_fixed_prio();
    test_lock();
    test_wait_states();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
